// File: rtl/dbg_byte_bridge.sv
// dbg_byte_bridge
// Host-side initiator for the core debug command port. It collects a 9-byte
// little-endian request (CMD, ADDR[4], DATA[4]) from a receive byte stream and
// issues it on dbg_cmd_o/dbg_addr_o/dbg_data_o. It then waits for dbg_ready_i
// and returns a 5-byte response (STATUS, RDATA[4]) on a transmit byte stream.
//
// Optional feature: define DBG_BRIDGE_TIMEOUT_EN to abort a command that has
// waited TIMEOUT cycles for dbg_ready_i. The response is then STATUS=8'hEE
// with zero read data. Without the macro the wait is unbounded and TIMEOUT is
// unused.
//
// Ports:
//   clk          system clock, rising edge
//   rstn_i       asynchronous active-low reset
//   rx_data_i    received byte, qualified by rx_valid_i (one-cycle strobe)
//   tx_data_o    byte to transmit, qualified by tx_valid_o
//   tx_valid_o   held high until tx_ready_i accepts the byte
//   tx_ready_i   transmitter accepts on tx_valid_o & tx_ready_i
//   dbg_cmd_o    debug command; 8'h00 = idle, nonzero only in ISSUE/WAIT
//   dbg_addr_o   debug address; holds its last value between commands
//   dbg_data_o   debug write data; holds its last value between commands
//   dbg_data_i   debug read data, valid while dbg_ready_i is high
//   dbg_ready_i  debug module completed the command (honoured in WAIT only)
module dbg_byte_bridge #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  dbg_cmd_o,
    output logic [31:0] dbg_addr_o,
    output logic [31:0] dbg_data_o,
    input  logic [31:0] dbg_data_i,
    input  logic        dbg_ready_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RX_ADDR = 3'd1;
    localparam logic [2:0] S_RX_DATA = 3'd2;
    localparam logic [2:0] S_ISSUE   = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_TX      = 3'd5;

    logic [2:0]  state_reg;
    logic [1:0]  byte_cnt_reg;
    logic [7:0]  cmd_lat_reg;
    logic [31:0] addr_sh_reg;
    logic [31:0] data_sh_reg;
    logic [7:0]  cmd_out_reg;
    logic [31:0] addr_out_reg;
    logic [31:0] data_out_reg;
    logic [7:0]  status_reg;
    logic [31:0] rdata_reg;
    logic [2:0]  tx_idx_reg;
    logic        timeout_hit;

`ifdef DBG_BRIDGE_TIMEOUT_EN
    logic [15:0] to_cnt_reg;
    // Success has priority: a timeout only fires while ready is still low.
    assign timeout_hit = (state_reg == S_WAIT) && !dbg_ready_i &&
                         (to_cnt_reg == 16'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Assembly shift registers are kept apart from the output registers so
    // dbg_addr_o/dbg_data_o do not ripple while a new frame is arriving.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg    <= S_IDLE;
            byte_cnt_reg <= 2'd0;
            cmd_lat_reg  <= 8'h00;
            addr_sh_reg  <= 32'h0;
            data_sh_reg  <= 32'h0;
            cmd_out_reg  <= 8'h00;
            addr_out_reg <= 32'h0;
            data_out_reg <= 32'h0;
            status_reg   <= 8'h00;
            rdata_reg    <= 32'h0;
            tx_idx_reg   <= 3'd0;
`ifdef DBG_BRIDGE_TIMEOUT_EN
            to_cnt_reg   <= 16'd0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    // A zero CMD byte is a resync filler and is discarded.
                    if (rx_valid_i && (rx_data_i != 8'h00)) begin
                        cmd_lat_reg  <= rx_data_i;
                        byte_cnt_reg <= 2'd0;
                        state_reg    <= S_RX_ADDR;
                    end
                end
                S_RX_ADDR: begin
                    if (rx_valid_i) begin
                        // Little-endian: first byte ends up in bits [7:0].
                        addr_sh_reg  <= {rx_data_i, addr_sh_reg[31:8]};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (byte_cnt_reg == 2'd3) begin
                            state_reg <= S_RX_DATA;
                        end
                    end
                end
                S_RX_DATA: begin
                    if (rx_valid_i) begin
                        data_sh_reg  <= {rx_data_i, data_sh_reg[31:8]};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (byte_cnt_reg == 2'd3) begin
                            cmd_out_reg  <= cmd_lat_reg;
                            addr_out_reg <= addr_sh_reg;
                            data_out_reg <= {rx_data_i, data_sh_reg[31:8]};
                            state_reg    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
`ifdef DBG_BRIDGE_TIMEOUT_EN
                    to_cnt_reg <= 16'd0;
`endif
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
`ifdef DBG_BRIDGE_TIMEOUT_EN
                    to_cnt_reg <= to_cnt_reg + 16'd1;
`endif
                    if (dbg_ready_i) begin
                        rdata_reg   <= dbg_data_i;
                        status_reg  <= 8'hA5;
                        cmd_out_reg <= 8'h00;
                        tx_idx_reg  <= 3'd0;
                        state_reg   <= S_TX;
                    end else if (timeout_hit) begin
                        rdata_reg   <= 32'h0;
                        status_reg  <= 8'hEE;
                        cmd_out_reg <= 8'h00;
                        tx_idx_reg  <= 3'd0;
                        state_reg   <= S_TX;
                    end
                end
                S_TX: begin
                    if (tx_ready_i) begin
                        if (tx_idx_reg == 3'd4) begin
                            tx_idx_reg <= 3'd0;
                            state_reg  <= S_IDLE;
                        end else begin
                            tx_idx_reg <= tx_idx_reg + 3'd1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Response frame as a byte array: STATUS then RDATA little-endian.
    logic [7:0] resp_bytes [5];
    assign resp_bytes[0] = status_reg;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_resp
            assign resp_bytes[gi + 1] = rdata_reg[8 * gi +: 8];
        end
    endgenerate

    always_comb begin
        tx_data_o = 8'h00;
        if (state_reg == S_TX) begin
            case (tx_idx_reg)
                3'd0:    tx_data_o = resp_bytes[0];
                3'd1:    tx_data_o = resp_bytes[1];
                3'd2:    tx_data_o = resp_bytes[2];
                3'd3:    tx_data_o = resp_bytes[3];
                3'd4:    tx_data_o = resp_bytes[4];
                default: tx_data_o = 8'h00;
            endcase
        end
    end

    assign tx_valid_o = (state_reg == S_TX);
    assign dbg_cmd_o  = cmd_out_reg;
    assign dbg_addr_o = addr_out_reg;
    assign dbg_data_o = data_out_reg;

endmodule

// File: tb/tb_dbg_byte_bridge.sv
module tb_dbg_byte_bridge;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_data_i;
    logic        dbg_ready_i;

    int pass_cnt  = 0;
    int check_cnt = 0;

    dbg_byte_bridge #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .dbg_cmd_o   (dbg_cmd_o),
        .dbg_addr_o  (dbg_addr_o),
        .dbg_data_o  (dbg_data_o),
        .dbg_data_i  (dbg_data_i),
        .dbg_ready_i (dbg_ready_i)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        next_cycle();
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
    endtask

    // Returns one cycle after the last DATA strobe (the ISSUE cycle).
    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [31:0] data);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(addr[8 * i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(data[8 * i +: 8]);
    endtask

    // Receives 5 response bytes; exp holds byte 0 in its top 8 bits.
    task automatic collect_tx(input string name, input logic [39:0] exp,
                              input bit bp, input bit inject);
        int k = 0;
        int cycles = 0;
        int low_run = 0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic [7:0] want;
        if (inject) begin
            rx_data_i  = 8'h07;
            rx_valid_i = 1'b1;
        end
        while (k < 5 && cycles < 200) begin
            if (prev_stall) begin
                check_cnt++;
                if (tx_valid_o !== 1'b1 || tx_data_o !== prev_data)
                    $display("FAIL %s_stable: got valid=%b data=%h, required valid=1 data=%h",
                             name, tx_valid_o, tx_data_o, prev_data);
                else pass_cnt++;
            end
            if (bp && low_run < 5 && $urandom_range(0, 1) == 0) begin
                tx_ready_i = 1'b0;
                low_run++;
            end else begin
                tx_ready_i = 1'b1;
                low_run = 0;
            end
            if (tx_valid_o === 1'b1 && tx_ready_i) begin
                want = exp[8 * (4 - k) +: 8];
                check_cnt++;
                if (tx_data_o !== want)
                    $display("FAIL %s_byte%0d: got %h, required %h", name, k, tx_data_o, want);
                else pass_cnt++;
                k++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = (tx_valid_o === 1'b1);
                prev_data  = tx_data_o;
            end
            next_cycle();
            cycles++;
        end
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        tx_ready_i = 1'b0;
        check_cnt++;
        if (k != 5) $display("FAIL %s_count: got %0d bytes, required 5", name, k);
        else pass_cnt++;
        check_cnt++;
        if (tx_valid_o !== 1'b0) $display("FAIL %s_end: got tx_valid=%b, required 0", name, tx_valid_o);
        else pass_cnt++;
        $display("txn %s: %0d response bytes in %0d cycles", name, k, cycles);
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rx_data_i   = 8'($urandom);
            rx_valid_i  = 1'($urandom);
            tx_ready_i  = 1'($urandom);
            dbg_data_i  = $urandom;
            dbg_ready_i = 1'($urandom);
            next_cycle();
        end
        check_cnt++;
        if (tx_valid_o !== 1'b0 || tx_data_o !== 8'h00)
            $display("FAIL reset_tx: got valid=%b data=%h, required 0/00", tx_valid_o, tx_data_o);
        else pass_cnt++;
        check_cnt++;
        if (dbg_cmd_o !== 8'h00) $display("FAIL reset_cmd: got %h, required 00", dbg_cmd_o);
        else pass_cnt++;
        check_cnt++;
        if (dbg_addr_o !== 32'h0 || dbg_data_o !== 32'h0)
            $display("FAIL reset_addr_data: got %h/%h, required 0/0", dbg_addr_o, dbg_data_o);
        else pass_cnt++;
        rx_data_i = 8'h00; rx_valid_i = 1'b0; tx_ready_i = 1'b0;
        dbg_data_i = 32'h0; dbg_ready_i = 1'b0;
        next_cycle();
        rstn_i = 1'b1;
        next_cycle();
        $display("txn reset: outputs checked under random inputs");
    endtask

    task automatic test_basic();
        send_frame(8'h01, 32'h0000_1000, 32'hDEAD_BEEF);
        check_cnt++;
        if (dbg_cmd_o !== 8'h01 || dbg_addr_o !== 32'h0000_1000 || dbg_data_o !== 32'hDEAD_BEEF)
            $display("FAIL basic_issue: got %h/%h/%h, required 01/00001000/deadbeef",
                     dbg_cmd_o, dbg_addr_o, dbg_data_o);
        else pass_cnt++;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            check_cnt++;
            if (dbg_cmd_o !== 8'h01 || dbg_addr_o !== 32'h0000_1000 ||
                dbg_data_o !== 32'hDEAD_BEEF || tx_valid_o !== 1'b0)
                $display("FAIL basic_hold%0d: got %h/%h/%h valid=%b, required 01/00001000/deadbeef valid=0",
                         i, dbg_cmd_o, dbg_addr_o, dbg_data_o, tx_valid_o);
            else pass_cnt++;
            next_cycle();
        end
        dbg_ready_i = 1'b1;
        dbg_data_i  = 32'h1234_5678;
        next_cycle();
        dbg_ready_i = 1'b0;
        dbg_data_i  = 32'h0;
        check_cnt++;
        if (dbg_cmd_o !== 8'h00 || tx_valid_o !== 1'b1 || tx_data_o !== 8'hA5)
            $display("FAIL basic_done: got cmd=%h valid=%b data=%h, required 00/1/a5",
                     dbg_cmd_o, tx_valid_o, tx_data_o);
        else pass_cnt++;
        collect_tx("basic", 40'hA5_78_56_34_12, 1'b0, 1'b0);
    endtask

    // Two resync zeros, then a frame completed on the first WAIT cycle.
    // Ready is already high during ISSUE, where it must be ignored.
    task automatic test_resync_earliest();
        send_byte(8'h00);
        send_byte(8'h00);
        send_frame(8'h02, 32'h8000_0004, 32'h0000_0001);
        check_cnt++;
        if (dbg_cmd_o !== 8'h02 || dbg_addr_o !== 32'h8000_0004 || dbg_data_o !== 32'h0000_0001)
            $display("FAIL resync_issue: got %h/%h/%h, required 02/80000004/00000001",
                     dbg_cmd_o, dbg_addr_o, dbg_data_o);
        else pass_cnt++;
        dbg_ready_i = 1'b1;
        dbg_data_i  = 32'hA1B2_C3D4;
        next_cycle();
        check_cnt++;
        if (tx_valid_o !== 1'b0 || dbg_cmd_o !== 8'h02)
            $display("FAIL earliest_wait: got valid=%b cmd=%h, required 0/02", tx_valid_o, dbg_cmd_o);
        else pass_cnt++;
        next_cycle();
        dbg_ready_i = 1'b0;
        dbg_data_i  = 32'h0;
        check_cnt++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hA5 || dbg_cmd_o !== 8'h00)
            $display("FAIL earliest_tx: got valid=%b data=%h cmd=%h, required 1/a5/00",
                     tx_valid_o, tx_data_o, dbg_cmd_o);
        else pass_cnt++;
        collect_tx("resync", 40'hA5_D4_C3_B2_A1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        send_frame(8'h9C, 32'h0102_0304, 32'h0506_0708);
        next_cycle();
        dbg_ready_i = 1'b1;
        dbg_data_i  = 32'hFACE_B00C;
        next_cycle();
        dbg_ready_i = 1'b0;
        collect_tx("backpressure", 40'hA5_0C_B0_CE_FA, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_rx();
        send_frame(8'h03, 32'h0000_ABCD, 32'h1122_3344);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            rx_valid_i = 1'b1;
            rx_data_i  = 8'h55;
            if (i == 2) begin
                dbg_ready_i = 1'b1;
                dbg_data_i  = 32'h0F0E_0D0C;
            end
            next_cycle();
        end
        dbg_ready_i = 1'b0;
        rx_valid_i  = 1'b0;
        check_cnt++;
        if (dbg_cmd_o !== 8'h00 || tx_valid_o !== 1'b1)
            $display("FAIL ignore_wait: got cmd=%h valid=%b, required 00/1", dbg_cmd_o, tx_valid_o);
        else pass_cnt++;
        collect_tx("ignore_tx", 40'hA5_0C_0D_0E_0F, 1'b0, 1'b1);
        send_frame(8'h08, 32'hFEDC_BA98, 32'h7654_3210);
        check_cnt++;
        if (dbg_cmd_o !== 8'h08 || dbg_addr_o !== 32'hFEDC_BA98 || dbg_data_o !== 32'h7654_3210)
            $display("FAIL ignore_next: got %h/%h/%h, required 08/fedcba98/76543210",
                     dbg_cmd_o, dbg_addr_o, dbg_data_o);
        else pass_cnt++;
        dbg_ready_i = 1'b1;
        dbg_data_i  = 32'h1357_9BDF;
        next_cycle();
        next_cycle();
        dbg_ready_i = 1'b0;
        collect_tx("ignore_next", 40'hA5_DF_9B_57_13, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_wait();
        bit saw_tx = 1'b0;
        send_frame(8'h04, 32'h0000_0040, 32'h0000_0080);
        next_cycle();
        next_cycle();
        check_cnt++;
        if (dbg_cmd_o !== 8'h04) $display("FAIL rstwait_pre: got %h, required 04", dbg_cmd_o);
        else pass_cnt++;
        #2;
        rstn_i = 1'b0;
        #1;
        check_cnt++;
        if (dbg_cmd_o !== 8'h00 || tx_valid_o !== 1'b0 || dbg_addr_o !== 32'h0)
            $display("FAIL rstwait_async: got cmd=%h valid=%b addr=%h, required 00/0/0",
                     dbg_cmd_o, tx_valid_o, dbg_addr_o);
        else pass_cnt++;
        dbg_ready_i = 1'b1;
        dbg_data_i  = 32'hFFFF_FFFF;
        next_cycle();
        next_cycle();
        rstn_i = 1'b1;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid_o !== 1'b0 || dbg_cmd_o !== 8'h00) saw_tx = 1'b1;
            next_cycle();
        end
        dbg_ready_i = 1'b0;
        tx_ready_i  = 1'b0;
        check_cnt++;
        if (saw_tx) $display("FAIL rstwait_quiet: got activity after reset, required none");
        else pass_cnt++;
        $display("txn reset_in_wait: done");
    endtask

`ifdef DBG_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        send_frame(8'h05, 32'h0000_0010, 32'h0000_0000);
        for (int i = 0; i < 8; i++) next_cycle();
        check_cnt++;
        if (dbg_cmd_o !== 8'h05 || tx_valid_o !== 1'b0)
            $display("FAIL timeout_last_wait: got cmd=%h valid=%b, required 05/0", dbg_cmd_o, tx_valid_o);
        else pass_cnt++;
        next_cycle();
        check_cnt++;
        if (dbg_cmd_o !== 8'h00 || tx_valid_o !== 1'b1 || tx_data_o !== 8'hEE)
            $display("FAIL timeout_abort: got cmd=%h valid=%b data=%h, required 00/1/ee",
                     dbg_cmd_o, tx_valid_o, tx_data_o);
        else pass_cnt++;
        collect_tx("timeout", 40'hEE_00_00_00_00, 1'b0, 1'b0);
        send_frame(8'h06, 32'h0000_0020, 32'h0000_0030);
        dbg_ready_i = 1'b1;
        dbg_data_i  = 32'h0BAD_F00D;
        next_cycle();
        next_cycle();
        dbg_ready_i = 1'b0;
        collect_tx("after_timeout", 40'hA5_0D_F0_AD_0B, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        rx_data_i = 8'h00; rx_valid_i = 1'b0; tx_ready_i = 1'b0;
        dbg_data_i = 32'h0; dbg_ready_i = 1'b0; rstn_i = 1'b1;
        #2;
        test_reset();
        test_basic();
        test_resync_earliest();
        test_backpressure();
        test_ignore_rx();
        test_reset_in_wait();
`ifdef DBG_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/dbg_byte_bridge.md
# dbg_byte_bridge

Host-side initiator for the core's debug command port. It assembles 9-byte command frames from an 8-bit receive byte stream, such as a UART receiver, and drives `dbg_cmd`/`dbg_addr`/`dbg_data` into the debug module. It waits for the debug module's ready handshake, then returns a 5-byte response frame (status plus read data) on an 8-bit transmit byte stream. It sits between the host link PHY and the core wrapper's debug inputs.

## Interface
Parameters:
- TIMEOUT, default 1024: cycles to wait for `dbg_ready_i` before aborting. Only used with `DBG_BRIDGE_TIMEOUT_EN`. Range 2..2^16-1.

Ports:
- clk  in  1  system clock, rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  one-cycle strobe; `rx_data_i` is valid this cycle
- tx_data_o  out  8  byte to transmit
- tx_valid_o  out  1  `tx_data_o` is valid; held until accepted
- tx_ready_i  in  1  transmitter accepts the byte when `tx_valid_o & tx_ready_i`
- dbg_cmd_o  out  8  debug command; 8'h00 = NOP/idle
- dbg_addr_o  out  32  debug address
- dbg_data_o  out  32  debug write data
- dbg_data_i  in  32  debug read data; valid when `dbg_ready_i` is high
- dbg_ready_i  in  1  debug module has completed the command

## Operation
- Request frame, 9 bytes: CMD, ADDR[7:0], ADDR[15:8], ADDR[23:16], ADDR[31:24], DATA[7:0], DATA[15:8], DATA[23:16], DATA[31:24]. Little-endian.
- Response frame, 5 bytes: STATUS, RDATA[7:0] .. RDATA[31:24].
  - STATUS = 8'hA5 on success.
  - STATUS = 8'hEE on timeout. RDATA is 0 on timeout.
- States:
  - IDLE: waits for `rx_valid_i`.
    - A CMD byte of 8'h00 is discarded and the state stays IDLE. This provides host resync.
    - Any other CMD byte is latched and the state goes to RX_ADDR.
  - RX_ADDR: shifts in 4 bytes with a 2-bit byte counter, then goes to RX_DATA.
  - RX_DATA: shifts in 4 bytes, then goes to ISSUE.
  - ISSUE: drives the latched cmd/addr/data for one cycle, then goes to WAIT.
  - WAIT: keeps cmd/addr/data stable. On the cycle `dbg_ready_i` is sampled high:
    - latch `dbg_data_i`;
    - set STATUS = 8'hA5;
    - go to TX.
  - TX: sends 5 bytes. The byte index advances only on `tx_valid_o & tx_ready_i`. After the 5th accepted byte, the state returns to IDLE.
- `dbg_cmd_o` is nonzero only in ISSUE and WAIT. It returns to 8'h00 on the cycle after `dbg_ready_i` is sampled.
- `dbg_addr_o` and `dbg_data_o` hold their last values when idle.
- `rx_valid_i` is ignored in ISSUE, WAIT and TX. Those bytes are dropped with no error reporting.
- `dbg_ready_i` is ignored outside WAIT.
- `tx_valid_o` is high only in TX.
- The bridge does not interpret the CMD value. Any nonzero code is forwarded unchanged.

## Timing
- Reset values:
  - `tx_valid_o` = 0, `tx_data_o` = 8'h00;
  - `dbg_cmd_o` = 8'h00, `dbg_addr_o` = 0, `dbg_data_o` = 0;
  - state = IDLE, byte counters = 0, timeout counter = 0.
- A reset asserted mid-frame or in WAIT returns to IDLE immediately and drops `dbg_cmd_o` to 0. No response is sent.
- The last DATA byte strobe is at cycle N:
  - `dbg_cmd_o` becomes valid at N+1 (ISSUE);
  - WAIT begins at N+2.
- Earliest completion: `dbg_ready_i` is sampled high in the first WAIT cycle, N+2. `tx_valid_o` rises at N+3 with the STATUS byte.
- Back-to-back `rx_valid_i` strobes, one per cycle, are accepted in IDLE, RX_ADDR and RX_DATA.
- TX: after an accept, the next byte is presented on the following cycle. The throughput is 1 byte/cycle when `tx_ready_i` is held high.
- A request byte strobed in the same cycle as the final TX accept is dropped. IDLE begins the next cycle.

## Configuration
- `DBG_BRIDGE_TIMEOUT_EN` defined:
  - a 16-bit counter clears on WAIT entry and increments every WAIT cycle;
  - if it reaches TIMEOUT-1 with `dbg_ready_i` low, the block drives `dbg_cmd_o` to 8'h00, sets STATUS = 8'hEE and RDATA = 0, and goes to TX;
  - if `dbg_ready_i` is high on that same cycle, success wins.
- Not defined: WAIT lasts indefinitely, the counter is not synthesized, and the TIMEOUT parameter is unused.

## Test plan
- Reset with random inputs: all outputs are 0 and `tx_valid_o` = 0. Assert `rstn_i` in WAIT: `dbg_cmd_o` goes to 0 asynchronously and no TX bytes follow.
- Bytes 01 00 10 00 00 EF BE AD DE, then `dbg_ready_i` high 3 cycles later with `dbg_data_i` = 0x12345678:
  - `dbg_cmd_o` = 8'h01, `dbg_addr_o` = 0x00001000 and `dbg_data_o` = 0xDEADBEEF, held stable until ready;
  - TX = A5 78 56 34 12.
- Leading 00 00 before a valid frame: both bytes are discarded and the frame executes normally.
- Random `tx_ready_i` backpressure, held low for up to 5 cycles: `tx_data_o` and `tx_valid_o` stay stable, and exactly 5 bytes are sent in order.
- With `DBG_BRIDGE_TIMEOUT_EN`, TIMEOUT = 8, `dbg_ready_i` never asserted:
  - `dbg_cmd_o` drops to 0 after 8 WAIT cycles;
  - TX = EE 00 00 00 00;
  - a following frame completes normally.
- Request bytes injected during WAIT and TX: they are ignored, and the next frame after IDLE decodes correctly.
